// File: rtl/exception_ctrl_pkg.sv
// exception_ctrl_pkg
//   Shared types and constants for the exception controller slice.
//   - exc_state_t     : controller FSM state encoding
//   - ESR_* codes     : exception syndrome values loaded into ESR on entry
//   - EXC_VECTOR_DEF  : default handler entry address
//   - esr_zext()      : zero-extends a syndrome onto the MRS read path
package exception_ctrl_pkg;

    localparam int unsigned N_DEF          = 64;
    localparam int unsigned ESR_W_DEF      = 4;
    localparam logic [63:0] EXC_VECTOR_DEF = 64'hD8;

    localparam logic [3:0] ESR_NONE       = 4'b0000;
    localparam logic [3:0] ESR_INVALID_OP = 4'b0001;
    localparam logic [3:0] ESR_IRQ        = 4'b0010;
    localparam logic [3:0] ESR_BAD_ERET   = 4'b0011;

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_TAKE    = 3'd1,
        S_HANDLER = 3'd2,
        S_RET     = 3'd3,
        S_HALT    = 3'd4
    } exc_state_t;

    // Zero-extend a 4-bit syndrome to a 64-bit system-register read value.
    function automatic logic [63:0] esr_zext(input logic [3:0] esr);
        return {60'd0, esr};
    endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// exception_ctrl_if
//   Bundles the decoder/PC-mux/IRQ/MRS signals of the exception controller.
//   master : core side (drives decoder info, IRQ line, MRS select)
//   slave  : exception_ctrl (drives flush/redirect, ELR/ESR, status, MRS data)
//   Port names follow the existing decoder signal names (NotAnInstr, ERet, ...).
interface exception_ctrl_if #(
    parameter int N     = 64,
    parameter int ESR_W = 4
);
    logic             instr_valid;
    logic             NotAnInstr;
    logic             ERet;
    logic [N-1:0]     pc_in;
    logic             ExtIRQ;
    logic             ExtAck;
    logic             Exc;
    logic             EReturn;
    logic [N-1:0]     redirect_pc;
    logic [N-1:0]     ELR;
    logic [ESR_W-1:0] ESR;
    logic             in_handler;
    logic             halted;
    logic             sysreg_sel;
    logic [N-1:0]     sysreg_rd;

    modport master (
        output instr_valid, NotAnInstr, ERet, pc_in, ExtIRQ, sysreg_sel,
        input  ExtAck, Exc, EReturn, redirect_pc, ELR, ESR, in_handler, halted, sysreg_rd
    );

    modport slave (
        input  instr_valid, NotAnInstr, ERet, pc_in, ExtIRQ, sysreg_sel,
        output ExtAck, Exc, EReturn, redirect_pc, ELR, ESR, in_handler, halted, sysreg_rd
    );
endinterface

// File: rtl/exception_ctrl_sync_2ff.sv
// exception_ctrl_sync_2ff
//   Two-flop synchroniser for the asynchronous external IRQ level.
//   clk   : destination clock
//   reset : asynchronous active-high reset (output forced low)
//   d     : asynchronous input
//   q     : synchronised output, two clk edges behind d
module exception_ctrl_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage shift resolving metastability on the first stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl
//   Sequences exception entry and return for the LEGv8 core: captures
//   ELR/ESR, issues one-cycle flush+redirect pulses to the PC mux,
//   acknowledges the external IRQ and serves ESR/ELR to MRS.
//   clk   : core clock
//   reset : asynchronous active-high reset (aborts any handler to RUN)
//   bus   : exception_ctrl_if.slave
//           in : instr_valid, NotAnInstr, ERet, pc_in, ExtIRQ, sysreg_sel
//           out: ExtAck, Exc, EReturn, redirect_pc, ELR, ESR, in_handler,
//                halted (all registered), sysreg_rd (combinational)
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int           N          = 64,
    parameter logic [N-1:0] EXC_VECTOR = N'(64'hD8),
    parameter int           ESR_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    exception_ctrl_if.slave   bus
);

    exc_state_t       state_r;
    exc_state_t       state_nxt_s;

    logic             irq_sync_s;
    logic             irq_pending_r;
    logic [2:0]       ack_dly_r;

    logic             take_s;
    logic [ESR_W-1:0] take_esr_s;

    logic [N-1:0]     elr_r;
    logic [ESR_W-1:0] esr_r;

    logic             exc_r;
    logic             ereturn_r;
    logic             ext_ack_r;
    logic [N-1:0]     redirect_pc_r;
    logic             in_handler_r;
    logic             halted_r;

    logic             exc_nxt_s;
    logic             ereturn_nxt_s;
    logic             ext_ack_nxt_s;
    logic [N-1:0]     redirect_pc_nxt_s;
    logic             in_handler_nxt_s;
    logic             halted_nxt_s;

    logic             valid_nai_s;
    logic             valid_eret_s;

    exception_ctrl_sync_2ff u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.ExtIRQ),
        .q     (irq_sync_s)
    );

    // Decoder flags only count for real (non-bubble) instructions.
    assign valid_nai_s  = bus.instr_valid & bus.NotAnInstr;
    assign valid_eret_s = bus.instr_valid & bus.ERet;

    // Pending-IRQ latch. The synced level keeps reading high for a few
    // cycles after the source drops, so it is ignored while ExtAck is
    // high and for three cycles after, so a source that drops right
    // after the ack does not re-enter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_pending_r <= 1'b0;
            ack_dly_r     <= 3'b000;
        end else begin
            ack_dly_r <= {ack_dly_r[1:0], ext_ack_r};
            if (ext_ack_r) begin
                irq_pending_r <= 1'b0;
            end else if (irq_sync_s && (ack_dly_r == 3'b000)) begin
                irq_pending_r <= 1'b1;
            end else begin
                irq_pending_r <= irq_pending_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and exception-entry selection.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        take_esr_s  = ESR_W'(ESR_NONE);
        case (state_r)
            S_RUN: begin
                if (valid_nai_s) begin
                    state_nxt_s = S_TAKE;
                    take_s      = 1'b1;
                    take_esr_s  = ESR_W'(ESR_INVALID_OP);
                end else if (valid_eret_s) begin
                    // ERET with no handler active is itself an exception.
                    state_nxt_s = S_TAKE;
                    take_s      = 1'b1;
                    take_esr_s  = ESR_W'(ESR_BAD_ERET);
                end else if (irq_pending_r) begin
                    state_nxt_s = S_TAKE;
                    take_s      = 1'b1;
                    take_esr_s  = ESR_W'(ESR_IRQ);
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_TAKE: begin
                state_nxt_s = S_HANDLER;
            end
            S_HANDLER: begin
                // A fault inside the handler is unrecoverable.
                if (valid_nai_s) begin
                    state_nxt_s = S_HALT;
                end else if (valid_eret_s) begin
                    state_nxt_s = S_RET;
                end else begin
                    state_nxt_s = S_HANDLER;
                end
            end
            S_RET: begin
                state_nxt_s = S_RUN;
            end
            S_HALT: begin
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_RUN;
            end
        endcase
    end

    // Output values for the cycle after this edge, decoded from the next state.
    always_comb begin
        exc_nxt_s         = 1'b0;
        ereturn_nxt_s     = 1'b0;
        in_handler_nxt_s  = 1'b0;
        halted_nxt_s      = 1'b0;
        redirect_pc_nxt_s = '0;
        ext_ack_nxt_s     = take_s && (take_esr_s == ESR_W'(ESR_IRQ));
        case (state_nxt_s)
            S_RUN: begin
                redirect_pc_nxt_s = '0;
            end
            S_TAKE: begin
                exc_nxt_s         = 1'b1;
                redirect_pc_nxt_s = EXC_VECTOR;
            end
            S_HANDLER: begin
                in_handler_nxt_s = 1'b1;
            end
            S_RET: begin
                ereturn_nxt_s     = 1'b1;
                in_handler_nxt_s  = 1'b1;
                redirect_pc_nxt_s = elr_r;
            end
            S_HALT: begin
                halted_nxt_s = 1'b1;
            end
            default: begin
                redirect_pc_nxt_s = '0;
            end
        endcase
    end

    // ELR/ESR capture on exception entry; frozen otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elr_r <= '0;
            esr_r <= '0;
        end else if (take_s) begin
            elr_r <= bus.pc_in;
            esr_r <= take_esr_s;
        end else begin
            elr_r <= elr_r;
            esr_r <= esr_r;
        end
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_r         <= 1'b0;
            ereturn_r     <= 1'b0;
            ext_ack_r     <= 1'b0;
            redirect_pc_r <= '0;
            in_handler_r  <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            exc_r         <= exc_nxt_s;
            ereturn_r     <= ereturn_nxt_s;
            ext_ack_r     <= ext_ack_nxt_s;
            redirect_pc_r <= redirect_pc_nxt_s;
            in_handler_r  <= in_handler_nxt_s;
            halted_r      <= halted_nxt_s;
        end
    end

    // MRS read mux: ESR zero-extended, or ELR.
    always_comb begin
        if (bus.sysreg_sel) begin
            bus.sysreg_rd = elr_r;
        end else begin
            bus.sysreg_rd = N'(esr_zext(4'(esr_r)));
        end
    end

    assign bus.Exc         = exc_r;
    assign bus.EReturn     = ereturn_r;
    assign bus.ExtAck      = ext_ack_r;
    assign bus.redirect_pc = redirect_pc_r;
    assign bus.ELR         = elr_r;
    assign bus.ESR         = esr_r;
    assign bus.in_handler  = in_handler_r;
    assign bus.halted      = halted_r;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl
//   Directed bench for exception_ctrl: entry/return, IRQ entry and ack,
//   priority against a pending IRQ, fatal halt, reset and MRS read.
module tb_exception_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    exception_ctrl_if #(.N(64), .ESR_W(4)) bus ();

    exception_ctrl #(.N(64), .EXC_VECTOR(64'hD8), .ESR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic nai, input logic eret, input logic [63:0] pc);
        bus.instr_valid = v;
        bus.NotAnInstr  = nai;
        bus.ERet        = eret;
        bus.pc_in       = pc;
    endtask

    initial begin
        int cyc;
        int seen;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.ExtIRQ     = 1'b0;
        bus.sysreg_sel = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        #2 reset = 1'b1;
        tick();
        tick();
        chk("rst_exc",        {63'd0, bus.Exc},        64'd0);
        chk("rst_eret",       {63'd0, bus.EReturn},    64'd0);
        chk("rst_ack",        {63'd0, bus.ExtAck},     64'd0);
        chk("rst_redirect",   bus.redirect_pc,         64'd0);
        chk("rst_elr",        bus.ELR,                 64'd0);
        chk("rst_esr",        {60'd0, bus.ESR},        64'd0);
        chk("rst_inh",        {63'd0, bus.in_handler}, 64'd0);
        chk("rst_halt",       {63'd0, bus.halted},     64'd0);
        reset = 1'b0;
        tick();

        // Invalid opcode at 0x40
        drive(1'b1, 1'b1, 1'b0, 64'h40);
        tick();
        chk("nai_exc",        {63'd0, bus.Exc},        64'd1);
        chk("nai_redirect",   bus.redirect_pc,         64'hD8);
        chk("nai_esr",        {60'd0, bus.ESR},        64'd1);
        chk("nai_elr",        bus.ELR,                 64'h40);
        chk("nai_ack",        {63'd0, bus.ExtAck},     64'd0);
        drive(1'b0, 1'b0, 1'b0, 64'h44);
        tick();
        chk("nai_exc_drop",   {63'd0, bus.Exc},        64'd0);
        chk("nai_inh",        {63'd0, bus.in_handler}, 64'd1);
        bus.sysreg_sel = 1'b0;
        #1;
        chk("mrs_esr",        bus.sysreg_rd,           64'd1);
        bus.sysreg_sel = 1'b1;
        #1;
        chk("mrs_elr",        bus.sysreg_rd,           64'h40);

        // Return from handler
        drive(1'b1, 1'b0, 1'b1, 64'hE0);
        tick();
        chk("ret_eret",       {63'd0, bus.EReturn},    64'd1);
        chk("ret_redirect",   bus.redirect_pc,         64'h40);
        chk("ret_inh",        {63'd0, bus.in_handler}, 64'd1);
        drive(1'b0, 1'b0, 1'b0, 64'h40);
        tick();
        chk("run_eret_drop",  {63'd0, bus.EReturn},    64'd0);
        chk("run_inh",        {63'd0, bus.in_handler}, 64'd0);

        // Bubble carrying NotAnInstr is ignored
        drive(1'b0, 1'b1, 1'b0, 64'h60);
        tick();
        chk("bubble_exc0",    {63'd0, bus.Exc},        64'd0);
        tick();
        chk("bubble_exc1",    {63'd0, bus.Exc},        64'd0);

        // External IRQ at pc 0x100
        drive(1'b1, 1'b0, 1'b0, 64'h100);
        bus.ExtIRQ = 1'b1;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cyc++;
            if (bus.Exc) break;
        end
        chk("irq_exc_seen",   {63'd0, bus.Exc},        64'd1);
        chk("irq_latency_ge3", {63'd0, (cyc >= 3)},    64'd1);
        chk("irq_esr",        {60'd0, bus.ESR},        64'd2);
        chk("irq_elr",        bus.ELR,                 64'h100);
        chk("irq_ack",        {63'd0, bus.ExtAck},     64'd1);
        chk("irq_redirect",   bus.redirect_pc,         64'hD8);
        bus.ExtIRQ = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("irq_ack_drop",   {63'd0, bus.ExtAck},     64'd0);
        drive(1'b1, 1'b0, 1'b1, 64'h200);
        tick();
        chk("irq_ret_redirect", bus.redirect_pc,       64'h100);
        drive(1'b0, 1'b0, 1'b0, 64'h100);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.Exc) seen++;
        end
        chk("irq_no_reentry", 64'(seen),               64'd0);

        // NotAnInstr beats a pending IRQ
        bus.ExtIRQ = 1'b1;
        tick();
        tick();
        tick();
        bus.ExtIRQ = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'h300);
        tick();
        chk("prio_exc",       {63'd0, bus.Exc},        64'd1);
        chk("prio_esr",       {60'd0, bus.ESR},        64'd1);
        chk("prio_ack",       {63'd0, bus.ExtAck},     64'd0);
        chk("prio_elr",       bus.ELR,                 64'h300);
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        tick();
        tick();
        chk("prio_masked",    {63'd0, bus.Exc},        64'd0);
        drive(1'b1, 1'b0, 1'b1, 64'h310);
        tick();
        chk("prio_ret",       bus.redirect_pc,         64'h300);
        drive(1'b0, 1'b0, 1'b0, 64'h320);
        tick();
        chk("prio_run_noexc", {63'd0, bus.Exc},        64'd0);
        tick();
        chk("prio_irq_exc",   {63'd0, bus.Exc},        64'd1);
        chk("prio_irq_esr",   {60'd0, bus.ESR},        64'd2);
        chk("prio_irq_ack",   {63'd0, bus.ExtAck},     64'd1);
        chk("prio_irq_elr",   bus.ELR,                 64'h320);
        tick();

        // Fault inside handler halts
        drive(1'b1, 1'b1, 1'b0, 64'h400);
        tick();
        chk("halt_set",       {63'd0, bus.halted},     64'd1);
        chk("halt_noexc",     {63'd0, bus.Exc},        64'd0);
        drive(1'b1, 1'b0, 1'b1, 64'h404);
        tick();
        chk("halt_sticky",    {63'd0, bus.halted},     64'd1);
        chk("halt_noeret",    {63'd0, bus.EReturn},    64'd0);
        reset = 1'b1;
        #1;
        chk("halt_rst",       {63'd0, bus.halted},     64'd0);
        chk("halt_rst_elr",   bus.ELR,                 64'd0);
        chk("halt_rst_esr",   {60'd0, bus.ESR},        64'd0);
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_halt",  {63'd0, bus.halted},     64'd0);

        // ERET outside a handler
        drive(1'b1, 1'b0, 1'b1, 64'h500);
        tick();
        chk("bad_eret_exc",   {63'd0, bus.Exc},        64'd1);
        chk("bad_eret_esr",   {60'd0, bus.ESR},        64'd3);
        bus.sysreg_sel = 1'b1;
        #1;
        chk("bad_eret_mrs",   bus.sysreg_rd,           64'h500);
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 64'h510);
        tick();
        chk("bad_eret_ret",   bus.redirect_pc,         64'h500);
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
